// File: rtl/rec_buf_rd_seq.sv
// rec_buf_rd_seq
//   Read-side sequencer for the ping-pong reconstruction buffer. On start_i it
//   walks one 64x64 LCU out of buffer read port 1, one 32-pixel row per access.
//   The buffer's fixed 1-cycle read latency is absorbed by a 2-entry output
//   queue. The queue streams rows, each tagged with its position, to a
//   valid/ready consumer.
//
//   Build option: define REC_RD_CHROMA_EN to append the 4:2:0 U and V planes
//   (192 rows per LCU). Without it the sequencer is luma only (128 rows) and
//   rd_sel_o stays 0.
//
//   pos_o encoding: {sel[1:0], blk[1:0], row[3:0]}.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module rec_buf_rd_seq #(
  parameter int PIX_W = `PIXEL_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  output logic                done_o,
  output logic                busy_o,
  output logic                rd_ena_o,
  output logic [1:0]          rd_sel_o,
  output logic [1:0]          rd_siz_o,
  output logic [3:0]          rd_4x4_x_o,
  output logic [3:0]          rd_4x4_y_o,
  output logic [4:0]          rd_idx_o,
  input  logic [32*PIX_W-1:0] rd_dat_i,
  output logic                val_o,
  input  logic                rdy_i,
  output logic [32*PIX_W-1:0] dat_o,
  output logic [7:0]          pos_o
);

  localparam int ROW_W = 32 * PIX_W;

  // Plane select codes on the buffer read port.
  localparam logic [1:0] SEL_Y = 2'd0;
`ifdef REC_RD_CHROMA_EN
  localparam logic [1:0] SEL_U = 2'd1;
  localparam logic [1:0] SEL_V = 2'd2;
`endif

  // Every access is a row of a 32x32 block.
  localparam logic [1:0] SIZ_32X32 = 2'd3;
  localparam logic [4:0] ROW_LAST  = 5'd31;
  localparam logic [1:0] BLK_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LUMA  = 3'd1,
`ifdef REC_RD_CHROMA_EN
    ST_CB    = 3'd2,
    ST_CR    = 3'd3,
`endif
    ST_DRAIN = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_e           state_q,    state_d;
  logic [4:0]       row_q,      row_d;       // row within the current block
  logic [1:0]       blk_q,      blk_d;       // luma block in Z order
  logic             fl_vld_q,   fl_vld_d;    // a read issued last cycle
  logic [7:0]       fl_pos_q,   fl_pos_d;    // position tag of that read
  logic [1:0]       q_cnt_q,    q_cnt_d;     // queue occupancy, 0..2
  logic             q_wr_ptr_q, q_wr_ptr_d;
  logic             q_rd_ptr_q, q_rd_ptr_d;

  logic [ROW_W-1:0] q_dat_mem [0:1];
  logic [7:0]       q_pos_mem [0:1];

  // ---------------------------------------------------------------------------
  // Internal combinational signals
  // ---------------------------------------------------------------------------
  logic             rd_ena;     // read issued this cycle
  logic [1:0]       plane;      // plane of the read being issued
  logic             lcu_done;   // DRAIN -> IDLE this cycle
  logic             push;       // read data lands in the queue this cycle
  logic             pop;        // head row accepted downstream this cycle
  logic             issue_ok;   // a read now cannot overflow the queue

  assign push  = fl_vld_q;
  assign val_o = (q_cnt_q != 2'd0);
  assign pop   = val_o & rdy_i;

  // Credits: rows queued plus the read in flight, less the row leaving now,
  // must stay below the queue depth.
  assign issue_ok = ({1'b0, q_cnt_q} + {2'b00, fl_vld_q}) < (3'd2 + {2'b00, pop});

  // Sequencer: next state, address counters and read strobe.
  // NOTE: every variable gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    blk_d    = blk_q;
    rd_ena   = 1'b0;
    plane    = SEL_Y;
    lcu_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LUMA;
          row_d   = 5'd0;
          blk_d   = 2'd0;
        end
      end

      ST_LUMA: begin
        plane = SEL_Y;
        if (issue_ok) begin
          rd_ena = 1'b1;
          row_d  = row_q + 5'd1;
          if (row_q == ROW_LAST) begin
            blk_d = blk_q + 2'd1;
            if (blk_q == BLK_LAST) begin
`ifdef REC_RD_CHROMA_EN
              state_d = ST_CB;
`else
              state_d = ST_DRAIN;
`endif
            end
          end
        end
      end

`ifdef REC_RD_CHROMA_EN
      ST_CB: begin
        plane = SEL_U;
        if (issue_ok) begin
          rd_ena = 1'b1;
          row_d  = row_q + 5'd1;
          if (row_q == ROW_LAST) begin
            state_d = ST_CR;
          end
        end
      end

      ST_CR: begin
        plane = SEL_V;
        if (issue_ok) begin
          rd_ena = 1'b1;
          row_d  = row_q + 5'd1;
          if (row_q == ROW_LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end
`endif

      ST_DRAIN: begin
        // An empty queue cannot be popping, so empty plus nothing in flight
        // means the last row has already left.
        if ((q_cnt_q == 2'd0) && !fl_vld_q) begin
          state_d  = ST_IDLE;
          lcu_done = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In-flight tracking: the position tag follows its read by one cycle.
  always_comb begin
    fl_vld_d = rd_ena;
    fl_pos_d = fl_pos_q;
    if (rd_ena) begin
      fl_pos_d = {plane, blk_q, row_q[3:0]};
    end
  end

  // Queue bookkeeping: pointers and occupancy.
  always_comb begin
    q_wr_ptr_d = q_wr_ptr_q;
    q_rd_ptr_d = q_rd_ptr_q;
    q_cnt_d    = q_cnt_q;
    if (push) begin
      q_wr_ptr_d = ~q_wr_ptr_q;
    end
    if (pop) begin
      q_rd_ptr_d = ~q_rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   q_cnt_d = q_cnt_q + 2'd1;
      2'b01:   q_cnt_d = q_cnt_q - 2'd1;
      default: q_cnt_d = q_cnt_q;
    endcase
  end

  // Control state registers; synchronous reset abandons any LCU in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= 5'd0;
      blk_q      <= 2'd0;
      fl_vld_q   <= 1'b0;
      fl_pos_q   <= 8'd0;
      q_cnt_q    <= 2'd0;
      q_wr_ptr_q <= 1'b0;
      q_rd_ptr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      blk_q      <= blk_d;
      fl_vld_q   <= fl_vld_d;
      fl_pos_q   <= fl_pos_d;
      q_cnt_q    <= q_cnt_d;
      q_wr_ptr_q <= q_wr_ptr_d;
      q_rd_ptr_q <= q_rd_ptr_d;
    end
  end

  // Queue storage: capture the returning row and its tag.
  // NOTE: the storage array has no reset; q_cnt_q decides which entries are
  // meaningful, and the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      q_dat_mem[q_wr_ptr_q] <= rd_dat_i;
      q_pos_mem[q_wr_ptr_q] <= fl_pos_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: address fields are driven only alongside the read strobe, and row
  // fields only while a row is valid. Otherwise they read 0.
  // ---------------------------------------------------------------------------
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = lcu_done;
  assign rd_ena_o   = rd_ena;
  assign rd_sel_o   = rd_ena ? plane : 2'd0;
  assign rd_siz_o   = rd_ena ? SIZ_32X32 : 2'd0;
  assign rd_4x4_x_o = rd_ena ? {blk_q[0], 3'b000} : 4'd0;
  assign rd_4x4_y_o = rd_ena ? {blk_q[1], 3'b000} : 4'd0;
  assign rd_idx_o   = rd_ena ? row_q : 5'd0;
  assign dat_o      = val_o ? q_dat_mem[q_rd_ptr_q] : '0;
  assign pos_o      = val_o ? q_pos_mem[q_rd_ptr_q] : 8'd0;

endmodule
